ps2_key_sender: RTL and testbench
=================================

# ps2_key_sender

Device-side PS/2 keyboard transmitter: the other end of the keyboard link that the display top receives from. It converts key events (press, release, or full tap, optionally extended) into the scan-code byte sequence and drives 11-bit PS/2 frames on `ps2_clk`/`ps2_data`. It is used to stimulate the receiver chain in simulation and to loop back on-board. Events arrive through a ready/valid-style request; one event is serialized at a time.

## Interface
- `CLK_DIV`, default 4: system clocks per PS/2 half-period. Allowed range 2–65535.
- `GAP_CYCLES`, default 8: idle-high system clocks between consecutive bytes of one event, and after the last byte. Minimum 1.
- `clk` input, 1 bit: single system clock. All logic is on the rising edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `key_code` input, 8 bits: scan code, sampled when a request is accepted.
- `key_ext` input, 1 bit: extended key; each code byte is prefixed with 0xE0.
- `key_press` input, 1 bit: request the make sequence.
- `key_release` input, 1 bit: request the break sequence. If both `key_press` and `key_release` are high, the request is a tap.
- `ready` output, 1 bit: the block can accept a request this cycle.
- `ps2_clk` output, 1 bit: PS/2 clock. Idles high.
- `ps2_data` output, 1 bit: PS/2 data. Idles high.
- `byte_done` output, 1 bit: one-cycle pulse at the end of each frame's stop bit.
- `busy` output, 1 bit: high from acceptance through the end of the final gap. Always equal to `~ready`.

## Operation
- **Acceptance:** a request is accepted when `ready & (key_press | key_release)` on a rising edge. `key_code` and `key_ext` are latched in the same cycle. Inputs are ignored while `busy`; there is no queueing.
- **Byte sequence by request type**, built into a 5-entry byte buffer with a 3-bit length:
  - press: [E0] code
  - release: [E0] F0 code
  - tap: [E0] code [E0] F0 code
  - The E0 entries appear only when `key_ext`=1. Maximum length is 5 (extended tap).
- **Frame:** 11 bits in this order:
  - start bit = 0
  - data[0] through data[7], LSB first
  - odd parity = `~^data`
  - stop bit = 1
- **Per bit:**
  - `ps2_data` is updated at the start of the bit while `ps2_clk` is high.
  - `ps2_clk` stays high for `CLK_DIV` cycles, then low for `CLK_DIV` cycles.
  - The receiver samples on the falling edge, so data setup time is `CLK_DIV` cycles.
- **State machine:** IDLE → LOAD → BIT_HI ↔ BIT_LO → GAP, then → LOAD (bytes remain) or → IDLE.
  - IDLE: outputs idle high, `ready`=1.
  - LOAD: fetch the next buffer entry, compute parity, reset the bit index to 0. Lasts 1 cycle.
  - BIT_HI: `ps2_clk`=1 for `CLK_DIV` cycles.
  - BIT_LO: `ps2_clk`=0 for `CLK_DIV` cycles. At the end, if bit index < 10, increment it and go to BIT_HI; otherwise pulse `byte_done` and go to GAP.
  - GAP: both lines high for `GAP_CYCLES` cycles.
- **Counters:**
  - The divider counter is 16 bits and reloads at each phase change.
  - The bit index is 4 bits and ranges 0–10.
  - The byte index is 3 bits. It is compared against the latched length; there is no wrap.
- **Outputs are registered:** `ps2_clk` and `ps2_data` come from flops, so there are no glitches.

## Timing
- **Reset values** (any time, including mid-frame):
  - `ps2_clk`=1, `ps2_data`=1, `ready`=1, `busy`=0, `byte_done`=0.
  - State = IDLE. Buffer, length and counters are cleared.
  - A partial frame is abandoned and no byte is resumed after reset.
- **Request latency:** accepted in cycle N → `ready`=0 in N+1 → LOAD in N+1 → start bit driven from N+2, with the first `ps2_clk` fall at N+2+`CLK_DIV`.
- **Frame duration:** 22·`CLK_DIV` cycles. `byte_done` is asserted on the last BIT_LO cycle of the stop bit.
- **Event duration:** len·(1 + 22·`CLK_DIV` + `GAP_CYCLES`) cycles. `ready` returns the cycle after the final GAP ends.
- **Simultaneous events:**
  - A request arriving in the same cycle `ready` rises is accepted.
  - press+release together is a tap, never two requests.
- No back-pressure from the host: this block does not sample the lines, and host inhibit is out of scope.

## Structure
- **Package `ps2_pkg`:**
  - localparams `PS2_BREAK`=8'hF0, `PS2_EXT`=8'hE0, `PS2_FRAME_BITS`=11
  - state enum {IDLE, LOAD, BIT_HI, BIT_LO, GAP}
- **Sub-module `ps2_frame_tx`:**
  - Serializes one byte: start/ack handshake, divider, bit index, parity.
  - The top-level `ps2_key_sender` owns the request latch, byte buffer/sequencer and GAP timing.

## Test plan
All scenarios use `CLK_DIV`=4 and `GAP_CYCLES`=8 unless stated.
- **Press 0x1C:** 0x1C has three ones, so parity=0.
  - Bits on the falling edges: 0, 0,0,1,1,1,0,0,0, 0, 1.
  - One `byte_done` pulse.
  - `ready` returns 1+88+8=97 cycles after acceptance +1.
- **Release 0x1C:** frames F0 (parity 1), then 1C. Two `byte_done` pulses, 97 cycles apart.
- **Extended tap of 0x75** (press=release=1, `key_ext`=1): frames E0, 75, E0, F0, 75. `busy` lasts 5·97 cycles.
- **Requests during `busy`:** a press of 0x29 issued mid-frame is ignored. The output stream is unchanged, and 0x29 is sent only if re-requested after `ready`=1.
- **`reset_n` low during bit 5:**
  - Both lines go high immediately and asynchronously; `ready`=1.
  - After release of reset, a new press of 0x1C produces a clean, full frame.
- **Loopback:** feed 0x1C through the team's PS/2 receiver. It must output data 0x1C, and `ready` rises once per frame with no overflow.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 constants, sequencer states and scan-code sequence builder
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, GAP} state_t;

    typedef struct packed {
        logic [4:0][7:0] bytes;
        logic [2:0]      len;
    } seq_t;

    // Make bytes first, then break bytes; a tap is simply both in that order.
    function automatic seq_t build_seq(input logic press, input logic rel, input logic ext,
                                       input logic [7:0] code);
        seq_t s;
        s = '0;
        if (press) begin
            if (ext) begin
                s.bytes[s.len] = PS2_EXT;
                s.len = s.len + 3'd1;
            end
            s.bytes[s.len] = code;
            s.len = s.len + 3'd1;
        end
        if (rel) begin
            if (ext) begin
                s.bytes[s.len] = PS2_EXT;
                s.len = s.len + 3'd1;
            end
            s.bytes[s.len] = PS2_BREAK;
            s.len = s.len + 3'd1;
            s.bytes[s.len] = code;
            s.len = s.len + 3'd1;
        end
        return s;
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// ps2_frame_tx: serializes one byte as an 11-bit PS/2 frame with registered clock/data lines
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       done
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  BIT_LAST = 4'(PS2_FRAME_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic [9:0]  sh_q, sh_d;
    logic        clk_q, clk_d;
    logic        dat_q, dat_d;
    logic        done_q, done_d;

    // Phase sequencing: data changes when the clock rises, so it is stable a full half-period before the fall.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        clk_d   = clk_q;
        dat_d   = dat_q;
        done_d  = state_q == BIT_LO && bit_q == BIT_LAST && div_q == 16'd1;
        case (state_q)
            BIT_HI: begin
                if (div_q == 16'd0) begin
                    state_d = BIT_LO;
                    div_d   = DIV_LAST;
                    clk_d   = 1'b0;
                end else begin
                    div_d = div_q - 16'd1;
                end
            end
            BIT_LO: begin
                if (div_q == 16'd0) begin
                    div_d = DIV_LAST;
                    clk_d = 1'b1;
                    if (bit_q == BIT_LAST) begin
                        state_d = IDLE;
                        dat_d   = 1'b1;
                    end else begin
                        state_d = BIT_HI;
                        bit_d   = bit_q + 4'd1;
                        dat_d   = sh_q[0];
                        sh_d    = {1'b1, sh_q[9:1]};
                    end
                end else begin
                    div_d = div_q - 16'd1;
                end
            end
            default: begin
                if (start) begin
                    state_d = BIT_HI;
                    div_d   = DIV_LAST;
                    bit_d   = 4'd0;
                    sh_d    = {1'b1, ~^data, data};
                    clk_d   = 1'b1;
                    dat_d   = 1'b0;
                end
            end
        endcase
    end

    // Serializer state; lines reset high so an abandoned frame leaves the bus idle at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            clk_q   <= 1'b1;
            dat_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            clk_q   <= clk_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
        end
    end

    assign ps2_clk  = clk_q;
    assign ps2_data = dat_q;
    assign done     = done_q;

endmodule

// File: rtl/ps2_key_sender.sv
// ps2_key_sender: turns key press/release/tap requests into PS/2 scan-code frames
module ps2_key_sender
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] key_code,
    input  logic       key_ext,
    input  logic       key_press,
    input  logic       key_release,
    output logic       ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       byte_done,
    output logic       busy
);

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    seq_t        seq_q, seq_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] gap_q, gap_d;
    logic        tx_start;
    logic        tx_done;
    logic [7:0]  tx_data;

    assign tx_start = state_q == LOAD;
    assign tx_data  = seq_q.bytes[idx_q];
    assign ready    = state_q == IDLE;
    assign busy     = ~ready;

    // Byte sequencer; BIT_HI here means a frame is in flight, the serializer owns the HI/LO phases.
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        case (state_q)
            IDLE: begin
                if (key_press | key_release) begin
                    seq_d   = build_seq(key_press, key_release, key_ext, key_code);
                    idx_d   = 3'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                idx_d   = idx_q + 3'd1;
                state_d = BIT_HI;
            end
            BIT_HI: begin
                if (tx_done) begin
                    state_d = GAP;
                    gap_d   = GAP_LAST;
                end
            end
            GAP: begin
                if (gap_q == 16'd0) state_d = idx_q == seq_q.len ? IDLE : LOAD;
                else gap_d = gap_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers; reset discards any pending bytes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            seq_q   <= '0;
            idx_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    ps2_frame_tx #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (tx_start),
        .data    (tx_data),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .done    (tx_done)
    );

    assign byte_done = tx_done;

endmodule

// File: tb/tb_ps2_key_sender.sv
// tb_ps2_key_sender: directed checks of frame contents, timing, busy blocking and reset abort
module tb_ps2_key_sender;

    localparam logic [10:0] FR_1C = {1'b1, 1'b0, 8'h1C, 1'b0};
    localparam logic [10:0] FR_F0 = {1'b1, 1'b1, 8'hF0, 1'b0};
    localparam logic [10:0] FR_E0 = {1'b1, 1'b0, 8'hE0, 1'b0};
    localparam logic [10:0] FR_75 = {1'b1, 1'b0, 8'h75, 1'b0};
    localparam logic [10:0] FR_29 = {1'b1, 1'b0, 8'h29, 1'b0};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_ext = 1'b0;
    logic       key_press = 1'b0;
    logic       key_release = 1'b0;
    logic       ready, ps2_clk, ps2_data, byte_done, busy;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          bc = 0;
    logic [10:0] sh = '0;
    logic [10:0] frames[$];
    int          done_at[$];

    always #5 clk = ~clk;

    ps2_key_sender #(.CLK_DIV(4), .GAP_CYCLES(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_press  (key_press),
        .key_release(key_release),
        .ready      (ready),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_done  (byte_done),
        .busy       (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (byte_done) done_at.push_back(cyc);

    // Receiver model: sample data on each falling PS/2 clock, first bit ends up in frame bit 0.
    always @(negedge ps2_clk or negedge reset_n) begin
        if (!reset_n) begin
            bc <= 0;
        end else if (bc == 10) begin
            frames.push_back({ps2_data, sh[10:1]});
            bc <= 0;
        end else begin
            sh <= {ps2_data, sh[10:1]};
            bc <= bc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int lim, output int k);
        k = 0;
        while (!ready && k < lim) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!ready) check("ready timeout", ready, 1);
    endtask

    task automatic request(input logic p, input logic r, input logic e, input logic [7:0] c);
        int k;
        wait_ready(1000, k);
        key_press   = p;
        key_release = r;
        key_ext     = e;
        key_code    = c;
        @(posedge clk);
        #1;
        key_press   = 1'b0;
        key_release = 1'b0;
        key_ext     = 1'b0;
        check("accept busy", busy, 1);
    endtask

    task automatic event_test(input string tag, input logic p, input logic r, input logic e,
                              input logic [7:0] c, input int n, input logic [10:0] exp [5]);
        int fb, db, k;
        fb = frames.size();
        db = done_at.size();
        request(p, r, e, c);
        k = 0;
        while (!ready && k < 600) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) check({tag, " start bit"}, ps2_data, 0);
            if (k == 4) check({tag, " clk high"}, ps2_clk, 1);
            if (k == 5) check({tag, " clk fall"}, ps2_clk, 0);
        end
        check({tag, " busy len"}, k, n * 97);
        check({tag, " frames"}, frames.size() - fb, n);
        for (int i = 0; i < n; i++)
            if (fb + i < frames.size()) check($sformatf("%s frame%0d", tag, i), frames[fb + i], exp[i]);
        check({tag, " byte_done"}, done_at.size() - db, n);
        for (int i = 1; i < n; i++)
            if (db + i < done_at.size())
                check($sformatf("%s spacing%0d", tag, i), done_at[db + i] - done_at[db + i - 1], 97);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fb, db, k;
        repeat (3) @(posedge clk);
        #1;
        check("reset ps2_clk", ps2_clk, 1);
        check("reset ps2_data", ps2_data, 1);
        check("reset ready", ready, 1);
        check("reset busy", busy, 0);
        check("reset byte_done", byte_done, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        event_test("press 1C", 1'b1, 1'b0, 1'b0, 8'h1C, 1, '{FR_1C, 11'h0, 11'h0, 11'h0, 11'h0});
        event_test("release 1C", 1'b0, 1'b1, 1'b0, 8'h1C, 2, '{FR_F0, FR_1C, 11'h0, 11'h0, 11'h0});
        event_test("ext tap 75", 1'b1, 1'b1, 1'b1, 8'h75, 5, '{FR_E0, FR_75, FR_E0, FR_F0, FR_75});
        event_test("ext release 75", 1'b0, 1'b1, 1'b1, 8'h75, 3, '{FR_E0, FR_F0, FR_75, 11'h0, 11'h0});

        // A press raised mid-frame and dropped before ready must be ignored.
        fb = frames.size();
        request(1'b1, 1'b0, 1'b0, 8'h1C);
        repeat (30) begin @(posedge clk); #1; end
        key_press = 1'b1;
        key_code  = 8'h29;
        repeat (20) begin @(posedge clk); #1; end
        key_press = 1'b0;
        key_code  = 8'h00;
        wait_ready(600, k);
        check("ignore busy len", 50 + k, 97);
        check("ignore frames", frames.size() - fb, 1);
        if (fb < frames.size()) check("ignore frame0", frames[fb], FR_1C);
        event_test("press 29", 1'b1, 1'b0, 1'b0, 8'h29, 1, '{FR_29, 11'h0, 11'h0, 11'h0, 11'h0});

        // A request held high is taken on the very cycle ready returns.
        fb = frames.size();
        request(1'b1, 1'b0, 1'b0, 8'h1C);
        key_press = 1'b1;
        key_code  = 8'h29;
        wait_ready(600, k);
        check("b2b first len", k, 97);
        @(posedge clk);
        #1;
        check("b2b accepted", ready, 0);
        key_press = 1'b0;
        key_code  = 8'h00;
        wait_ready(600, k);
        check("b2b frames", frames.size() - fb, 2);
        if (fb + 1 < frames.size()) begin
            check("b2b frame0", frames[fb], FR_1C);
            check("b2b frame1", frames[fb + 1], FR_29);
        end

        // Reset while bit 5 is on the wire abandons the frame.
        fb = frames.size();
        db = done_at.size();
        request(1'b1, 1'b0, 1'b0, 8'h1C);
        repeat (46) begin @(posedge clk); #1; end
        check("pre-reset clk low", ps2_clk, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort ps2_clk", ps2_clk, 1);
        check("abort ps2_data", ps2_data, 1);
        check("abort ready", ready, 1);
        check("abort busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("abort no frame", frames.size() - fb, 0);
        check("abort no byte_done", done_at.size() - db, 0);
        @(posedge clk);
        #1;
        event_test("post-reset 1C", 1'b1, 1'b0, 1'b0, 8'h1C, 1, '{FR_1C, 11'h0, 11'h0, 11'h0, 11'h0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
